selector_arbiter: RTL
=====================

# selector_arbiter

Two-requester round-robin arbiter that sequences the 2:1 `data_selector` datapath. It decides which of two sources (A or B) owns the shared output, drives the selector's SEL line, and registers the selected data with a valid flag. It sits directly in front of the selector: the requesters talk to this block, and the selector only ever sees a SEL that this block has decided.

## Interface
- `WIDTH`, default 1: data width of each source and of Q.
- `HOLD_MAX`, default 8: maximum consecutive grant cycles while the other side waits; must be ≥ 2.
- `CLK` input 1: rising-edge clock.
- `RST_N` input 1: reset; one clock, synchronous, active-low.
- `REQ_A` input 1: source A requests the output; level, held until done.
- `REQ_B` input 1: source B requests the output.
- `DATA_A` input WIDTH: source A data.
- `DATA_B` input WIDTH: source B data.
- `GNT_A` output 1: A owns the output this cycle (registered).
- `GNT_B` output 1: B owns the output this cycle (registered).
- `SEL` output 1: selector control; 1 selects A, 0 selects B (registered).
- `Q` output WIDTH: registered selected data.
- `Q_VALID` output 1: Q carries data from a granted source.

## Operation
- States:
  - IDLE: no grant.
  - GRANT_A: GNT_A=1, SEL=1.
  - GRANT_B: GNT_B=1, SEL=0.
- `last` pointer: the side most recently granted. Reset value B, so A wins the first tie.
- From IDLE:
  - Both REQ high: grant the side ≠ `last`.
  - One REQ high: grant that side.
  - Neither high: stay in IDLE.
- From GRANT_X, own REQ low:
  - Other REQ high: go straight to the other GRANT, with no idle cycle.
  - Otherwise: go to IDLE.
- From GRANT_X, own REQ high: stay, unless the timeout below fires.
- Hold counter, width clog2(HOLD_MAX+1):
  - Cleared on every grant entry.
  - Increments each GRANT cycle in which the other REQ is high.
  - Holds its value otherwise.
- Timeout: counter == HOLD_MAX−1 with both REQ high forces a switch to the other GRANT. A single grant therefore lasts at most HOLD_MAX cycles while the other side waits.
- `last` updates on every grant entry.
- SEL keeps its last value in IDLE.
- Datapath: each cycle, Q <= SEL ? DATA_A : DATA_B and Q_VALID <= GNT_A|GNT_B.
- Q keeps its value when Q_VALID=0.
- GNT_A and GNT_B are never both 1.

## Timing
- All outputs are registered. Reset values: GNT_A=0, GNT_B=0, SEL=0, Q=0, Q_VALID=0, state IDLE, counter 0, `last`=B.
- Reset behaviour:
  - RST_N low at a rising edge forces all of the above at that edge, including mid-grant.
  - REQ is ignored while RST_N is low.
- Grant latency: REQ high at edge n produces GNT high after edge n.
- Release latency: REQ low at edge n produces GNT low after edge n. The handoff grant appears in that same cycle.
- Data latency: DATA of the granted source in cycle c appears on Q with Q_VALID=1 in cycle c+1.
- Back-to-back requests: if the requester drops REQ and raises it again one cycle later, it is re-granted only if the other side is not requesting. Otherwise round-robin applies.
- Simultaneous REQ rise from IDLE: the side ≠ `last` is granted.

## Configuration
- `SELECTOR_TIMEOUT_EN` defined: the hold counter and forced switch are built as described.
- `SELECTOR_TIMEOUT_EN` undefined:
  - Counter logic is removed and `HOLD_MAX` is ignored.
  - A grant persists while its REQ stays high, regardless of the other side.
  - Round-robin still applies at IDLE ties and at release.

## Test plan
- Reset: RST_N low 2 cycles with REQ_A=REQ_B=1 -> all outputs 0. First edge with RST_N high -> GNT_A=1, SEL=1. Next cycle -> Q=DATA_A, Q_VALID=1.
- Single source: REQ_B high 5 cycles, DATA_B=1, WIDTH=1 -> GNT_B high 5 cycles starting one cycle later, SEL=0, Q=1 with Q_VALID for 5 cycles after a further cycle. Then IDLE with Q_VALID=0 and SEL still 0.
- Contention with timeout (macro defined, HOLD_MAX=4): both REQ held high 24 cycles -> GNT_A 4 cycles, GNT_B 4, GNT_A 4, and so on, with no gap and never both high.
- Handoff: GRANT_A active, REQ_B high, REQ_A drops at edge n -> GNT_A=0 and GNT_B=1 after edge n. Q switches to DATA_B one cycle later with Q_VALID staying 1.
- Reset mid-operation: RST_N low during GRANT_B with counter at 2 -> outputs 0 after that edge. After release with both REQ high -> GNT_A wins (`last` reset to B).
- Timeout compiled out (macro undefined): both REQ high 100 cycles -> GNT_A high all 100 cycles. REQ_A drops -> GNT_B the next cycle.

Source files
------------

// File: rtl/selector_arbiter_if.sv
// rtl/selector_arbiter_if.sv - requester/selector bus shared by selector_arbiter and its requesters
//
// Purpose: bundles the two request/data sources and the arbitrated output
//          of selector_arbiter into one interface.
// Signals:
//   REQ_A, REQ_B     requests from source A / source B (level, held until done)
//   DATA_A, DATA_B   source data, WIDTH bits each
//   GNT_A, GNT_B     grant to A / B (never both high)
//   SEL              selector control, 1 selects A, 0 selects B
//   Q, Q_VALID       registered selected data and its valid flag
// Modports:
//   master  requester side (drives REQ/DATA, observes grants and output)
//   slave   arbiter side (observes REQ/DATA, drives grants and output)
interface selector_arbiter_if #(
  parameter int WIDTH = 1
);
  logic             REQ_A;
  logic             REQ_B;
  logic [WIDTH-1:0] DATA_A;
  logic [WIDTH-1:0] DATA_B;
  logic             GNT_A;
  logic             GNT_B;
  logic             SEL;
  logic [WIDTH-1:0] Q;
  logic             Q_VALID;

  modport master (
    output REQ_A, REQ_B, DATA_A, DATA_B,
    input  GNT_A, GNT_B, SEL, Q, Q_VALID
  );

  modport slave (
    input  REQ_A, REQ_B, DATA_A, DATA_B,
    output GNT_A, GNT_B, SEL, Q, Q_VALID
  );
endinterface

// File: rtl/selector_arbiter.sv
// rtl/selector_arbiter.sv - two-requester round-robin arbiter driving a 2:1 data selector
//
// Purpose: decides which of sources A/B owns the shared output, drives the
//          selector SEL line and registers the selected data with a valid flag.
// Parameters:
//   WIDTH     data width of each source and of Q
//   HOLD_MAX  longest grant (in cycles) while the other side waits; >= 2
// Ports:
//   CLK       rising-edge clock
//   RST_N     synchronous active-low reset
//   bus       selector_arbiter_if.slave (REQ_A/B, DATA_A/B in; GNT_A/B, SEL, Q, Q_VALID out)
// Build option:
//   SELECTOR_TIMEOUT_EN  when defined, a hold counter forces a switch after
//                        HOLD_MAX contended cycles; when undefined a grant
//                        lasts as long as its request and HOLD_MAX is unused.
module selector_arbiter #(
  parameter int WIDTH    = 1,
  parameter int HOLD_MAX = 8
) (
  input logic               CLK,
  input logic               RST_N,
  selector_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             last_a_q;     // 1: A was granted most recently, 0: B
  logic             sel_q;
  logic [WIDTH-1:0] q_q;
  logic             q_valid_q;
  logic             grant_entry;  // a new grant begins at the coming edge
  logic             timeout_hit;
  logic             req_a;
  logic             req_b;

  assign req_a = bus.REQ_A;
  assign req_b = bus.REQ_B;

`ifdef SELECTOR_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

  logic [CNT_W-1:0] hold_cnt_q;
  logic             other_waiting;

  assign other_waiting = ((state_q == GRANT_A) && req_b) ||
                         ((state_q == GRANT_B) && req_a);

  // Only meaningful in a GRANT state; IDLE decisions never look at it.
  assign timeout_hit = req_a && req_b && (hold_cnt_q == CNT_LAST);

  // Counts cycles the non-owner has been kept waiting in the current grant.
  // It cannot pass CNT_LAST: at CNT_LAST with the other side waiting the
  // grant either times out or is released, and both restart the count.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      hold_cnt_q <= '0;
    end else if (grant_entry) begin
      hold_cnt_q <= '0;
    end else if (other_waiting) begin
      hold_cnt_q <= hold_cnt_q + CNT_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;

  // HOLD_MAX has no effect without the timeout logic.
  logic unused_hold_max;
  assign unused_hold_max = (HOLD_MAX >= 2);
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decision. A release hands straight over to a waiting
  // requester so the output never idles while someone is asking.
  always_comb begin
    state_d     = state_q;
    grant_entry = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_a && req_b) begin
          state_d = last_a_q ? GRANT_B : GRANT_A;
        end else if (req_a) begin
          state_d = GRANT_A;
        end else if (req_b) begin
          state_d = GRANT_B;
        end
      end
      GRANT_A: begin
        if (!req_a) begin
          state_d = req_b ? GRANT_B : IDLE;
        end else if (timeout_hit) begin
          state_d = GRANT_B;
        end
      end
      GRANT_B: begin
        if (!req_b) begin
          state_d = req_a ? GRANT_A : IDLE;
        end else if (timeout_hit) begin
          state_d = GRANT_A;
        end
      end
      default: state_d = IDLE;
    endcase
    grant_entry = (state_d != IDLE) && (state_d != state_q);
  end

  // Grant bookkeeping and datapath. SEL moves only when a new grant starts,
  // so it keeps its last value through IDLE. Q loads only while a grant is
  // active, which leaves it unchanged whenever Q_VALID is low.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      last_a_q  <= 1'b0;
      sel_q     <= 1'b0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
    end else begin
      if (grant_entry) begin
        last_a_q <= (state_d == GRANT_A);
        sel_q    <= (state_d == GRANT_A);
      end
      if (state_q != IDLE) begin
        q_q <= sel_q ? bus.DATA_A : bus.DATA_B;
      end
      q_valid_q <= (state_q != IDLE);
    end
  end

  assign bus.GNT_A   = (state_q == GRANT_A);
  assign bus.GNT_B   = (state_q == GRANT_B);
  assign bus.SEL     = sel_q;
  assign bus.Q       = q_q;
  assign bus.Q_VALID = q_valid_q;

endmodule
